// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : systolic_result_drain
// Purpose  : Captures the four 2x2 systolic-array results on done_in, with
//            optional ReLU, and streams them one element per valid/ready beat
//            tagged with element index and tile number. A tile that arrives
//            while the previous one is still draining is dropped and flagged.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_result_drain #(
  parameter int DATA_W  = 8,
  parameter int TILE_W  = 6,
  parameter int RELU_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_in,
  input  logic [DATA_W-1:0] result11,
  input  logic [DATA_W-1:0] result12,
  input  logic [DATA_W-1:0] result21,
  input  logic [DATA_W-1:0] result22,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic [TILE_W-1:0] out_tile,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              tile_done,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SEND = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [DATA_W-1:0] r_bank [4];
  logic [TILE_W-1:0] r_bank_tile;
  logic [TILE_W-1:0] r_tile_cnt;
  logic [1:0]        r_idx;
  logic              r_tile_done;
  logic              r_overrun;

  logic [DATA_W-1:0] w_raw [4];
  logic [DATA_W-1:0] w_cap [4];
  logic              w_send;
  logic              w_hs;
  logic              w_last_hs;
  logic              w_capture;
  logic              w_drop;
  logic [TILE_W-1:0] w_tile_nxt;

  assign w_raw[0] = result11;
  assign w_raw[1] = result12;
  assign w_raw[2] = result21;
  assign w_raw[3] = result22;

  // Per-element capture value: clamp negatives to zero only when ReLU is built in
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_elem
      if (RELU_EN != 0) begin : g_relu
        assign w_cap[gi] = w_raw[gi][DATA_W-1] ? '0 : w_raw[gi];
      end else begin : g_pass
        assign w_cap[gi] = w_raw[gi];
      end
    end
  endgenerate

  // A new tile is accepted when idle, or when the final beat of the current
  // tile is leaving in the same cycle (no bubble between tiles).
  assign w_send     = (r_state == c_SEND);
  assign w_hs       = w_send & out_ready;
  assign w_last_hs  = w_hs & (r_idx == 2'd3);
  assign w_capture  = done_in & (~w_send | w_last_hs);
  assign w_drop     = done_in & w_send & ~w_last_hs;
  assign w_tile_nxt = r_tile_cnt + TILE_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (done_in) w_state_nxt = c_SEND;
      c_SEND:  if (w_last_hs && !done_in) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output decode: stream fields are driven only while a tile is held
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_tile  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (r_state == c_SEND) begin
      out_valid = 1'b1;
      out_data  = r_bank[r_idx];
      out_idx   = r_idx;
      out_tile  = r_bank_tile;
      out_last  = (r_idx == 2'd3);
      busy      = 1'b1;
    end
  end

  assign tile_done = r_tile_done;
  assign overrun   = r_overrun;

  // Holding bank, element index, tile counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_bank[i] <= '0;
      r_bank_tile <= '0;
      r_tile_cnt  <= '0;
      r_idx       <= '0;
      r_tile_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_tile_done <= w_last_hs;
      if (w_last_hs) r_tile_cnt <= w_tile_nxt;
      if (w_capture) begin
        for (int i = 0; i < 4; i++) r_bank[i] <= w_cap[i];
        // A back-to-back tile takes the number after the one just finishing
        r_bank_tile <= w_last_hs ? w_tile_nxt : r_tile_cnt;
        r_idx       <= '0;
      end else if (w_hs) begin
        r_idx <= r_idx + 2'd1;
      end
      // Setting wins over a simultaneous clear
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_result_drain
// Purpose  : Self-checking bench. dut0 uses default parameters; dut1 has ReLU
//            enabled and a 2-bit tile counter. Both see the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_result_drain;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
    logic [5:0] tile;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done_in = 1'b0;
  logic [7:0] result11 = '0, result12 = '0, result21 = '0, result22 = '0;
  logic       out_ready = 1'b1;
  logic       clr_overrun = 1'b0;

  logic [7:0] d0_data, d1_data;
  logic [1:0] d0_idx, d1_idx;
  logic [5:0] d0_tile;
  logic [1:0] d1_tile;
  logic       d0_valid, d0_last, d0_busy, d0_tdone, d0_ovr;
  logic       d1_valid, d1_last, d1_busy, d1_tdone, d1_ovr;

  int checks = 0;
  int failures = 0;
  int m_tile = 0;
  beat_t exp0[$];
  beat_t exp1[$];

  systolic_result_drain #(.DATA_W(8), .TILE_W(6), .RELU_EN(0)) dut0 (
    .clk(clk), .rst(rst), .done_in(done_in),
    .result11(result11), .result12(result12), .result21(result21), .result22(result22),
    .out_data(d0_data), .out_idx(d0_idx), .out_tile(d0_tile), .out_valid(d0_valid),
    .out_ready(out_ready), .out_last(d0_last), .busy(d0_busy), .tile_done(d0_tdone),
    .overrun(d0_ovr), .clr_overrun(clr_overrun)
  );

  systolic_result_drain #(.DATA_W(8), .TILE_W(2), .RELU_EN(1)) dut1 (
    .clk(clk), .rst(rst), .done_in(done_in),
    .result11(result11), .result12(result12), .result21(result21), .result22(result22),
    .out_data(d1_data), .out_idx(d1_idx), .out_tile(d1_tile), .out_valid(d1_valid),
    .out_ready(out_ready), .out_last(d1_last), .busy(d1_busy), .tile_done(d1_tdone),
    .overrun(d1_ovr), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(logic [7:0] d, int i, int t);
    beat_t b;
    b.data = d;
    b.idx  = 2'(i);
    b.tile = 6'(t);
    b.last = (i == 3);
    return b;
  endfunction

  // Expected beats for an accepted tile, for both DUTs
  task automatic push_tile(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
    logic [7:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      exp0.push_back(mk(v[i], i, m_tile % 64));
      exp1.push_back(mk(v[i][7] ? 8'h00 : v[i], i, m_tile % 4));
    end
    m_tile++;
  endtask

  // One clock: scoreboard pops on every accepted beat (sampled at negedge),
  // then returns 1 time unit after the next rising edge.
  task automatic tick();
    beat_t got;
    beat_t e;
    @(negedge clk);
    if (d0_valid && out_ready) begin
      checks++;
      got = '{d0_data, d0_idx, d0_tile, d0_last};
      if (exp0.size() == 0) begin
        failures++;
        $display("FAIL sb_dut0 unexpected beat got=%h", got);
      end else begin
        e = exp0.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL sb_dut0 got=%h exp=%h", got, e);
        end
      end
    end
    if (d1_valid && out_ready) begin
      checks++;
      got = '{d1_data, d1_idx, {4'b0, d1_tile}, d1_last};
      if (exp1.size() == 0) begin
        failures++;
        $display("FAIL sb_dut1 unexpected beat got=%h", got);
      end else begin
        e = exp1.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL sb_dut1 got=%h exp=%h", got, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic launch(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d, bit expect_accept);
    done_in = 1'b1;
    result11 = a; result12 = b; result21 = c; result22 = d;
    if (expect_accept) push_tile(a, b, c, d);
    tick();
    done_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp0.delete();
    exp1.delete();
    m_tile = 0;
  endtask

  // Drain remaining expected beats (bounded), land on the tile_done cycle
  task automatic drain(string name);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp0.size() > 0; i++) tick();
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      failures++;
      $display("FAIL %s_drain left=%0d/%0d required=0", name, exp0.size(), exp1.size());
      exp0.delete();
      exp1.delete();
    end
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    rst = 1'b1;
    tick();
    tick();
    obs = {d0_valid, d0_data, d0_idx, d0_tile, d0_last, d0_busy, d0_tdone, d0_ovr};
    checks++;
    if (obs !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", obs);
    end
    do_reset();
  endtask

  task automatic test_basic();
    logic [4:0] obs;
    logic [4:0] req;
    do_reset();
    out_ready = 1'b1;
    launch(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    for (int k = 0; k < 4; k++) begin
      obs = {d0_valid, d0_idx, d0_last, d0_tdone};
      req = {1'b1, 2'(k), (k == 3), 1'b0};
      checks++;
      if (obs !== req) begin
        failures++;
        $display("FAIL basic_beat%0d got=%b required=%b", k, obs, req);
      end
      tick();
    end
    obs = {d0_tdone, d0_valid, d0_busy, 2'b00};
    checks++;
    if (obs !== 5'b10000 || exp0.size() != 0) begin
      failures++;
      $display("FAIL basic_tile_done got=%b required=10000 left=%0d", obs, exp0.size());
    end
    tick();
    checks++;
    if (d0_tdone !== 1'b0) begin
      failures++;
      $display("FAIL basic_tile_done_pulse got=%b required=0", d0_tdone);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    launch(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d0_data !== 8'h22 || d0_idx !== 2'd1 || d0_valid !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold%0d got=%h/%0d/%b required=22/1/1", k, d0_data, d0_idx, d0_valid);
      end
      tick();
    end
    drain("backpressure");
    checks++;
    if (d0_tdone !== 1'b1 || d0_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_end got=%b%b required=10", d0_tdone, d0_valid);
    end
  endtask

  task automatic test_overrun();
    out_ready = 1'b1;
    launch(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    tick();
    out_ready = 1'b0;
    launch(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0);
    checks++;
    if (d0_ovr !== 1'b1 || d0_data !== 8'h22 || d0_idx !== 2'd1) begin
      failures++;
      $display("FAIL overrun_set got=%b/%h/%0d required=1/22/1", d0_ovr, d0_data, d0_idx);
    end
    clr_overrun = 1'b1;
    launch(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0);
    clr_overrun = 1'b0;
    checks++;
    if (d0_ovr !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set_wins got=%b required=1", d0_ovr);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++;
    if (d0_ovr !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got=%b required=0", d0_ovr);
    end
    drain("overrun");
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    launch(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    tick();
    tick();
    tick();
    launch(8'h55, 8'h66, 8'h77, 8'h88, 1'b1);
    checks++;
    if (d0_valid !== 1'b1 || d0_idx !== 2'd0 || d0_data !== 8'h55 || d0_tile !== 6'd1 ||
        d0_tdone !== 1'b1 || d0_ovr !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_join got=%b/%0d/%h/%0d/%b/%b required=1/0/55/1/1/0",
               d0_valid, d0_idx, d0_data, d0_tile, d0_tdone, d0_ovr);
    end
    tick();
    checks++;
    if (d0_tdone !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_pulse got=%b required=0", d0_tdone);
    end
    drain("back_to_back");
    checks++;
    if (d0_tdone !== 1'b1 || d0_ovr !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_end got=%b%b required=10", d0_tdone, d0_ovr);
    end
    tick();
  endtask

  task automatic test_relu();
    out_ready = 1'b1;
    launch(8'h80, 8'h7F, 8'hFF, 8'h00, 1'b1);
    checks++;
    if (d1_data !== 8'h00 || d0_data !== 8'h80) begin
      failures++;
      $display("FAIL relu_first got=%h/%h required=00/80", d1_data, d0_data);
    end
    drain("relu");
    tick();
  endtask

  task automatic test_reset_mid_and_wrap();
    logic [20:0] obs;
    out_ready = 1'b1;
    launch(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs = {d0_valid, d0_data, d0_idx, d0_tile, d0_last, d0_busy, d0_tdone, d0_ovr};
    checks++;
    if (obs !== 21'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h required=0", obs);
    end
    exp0.delete();
    exp1.delete();
    m_tile = 0;
    tick();
    checks++;
    if (d0_tdone !== 1'b0 || d1_tdone !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_tile_done got=%b%b required=00", d0_tdone, d1_tdone);
    end
    for (int t = 0; t < 5; t++) begin
      launch(8'(t + 1), 8'h81, 8'h02, 8'h03, 1'b1);
      checks++;
      if (d1_tile !== 2'(t % 4)) begin
        failures++;
        $display("FAIL wrap_tile%0d got=%0d required=%0d", t, d1_tile, t % 4);
      end
      drain("wrap");
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_relu();
    test_reset_mid_and_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Consumes the four parallel results and the one-cycle done pulse from the 2x2 convolution systolic array.
- Captures the four results into a holding bank, with optional ReLU.
- Streams them one element per beat over a valid/ready interface to the downstream feature-map writer, tagged with element index and tile number.
- Flags tiles that arrive while a previous tile is still draining.

Parameters:
DATA_W, 8, width of each result element and of out_data
TILE_W, 6, width of the tile counter (wraps at 2^TILE_W)
RELU_EN, 0, 1 = clamp elements with MSB set (negative in two's complement) to 0 at capture

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
done_in  input  1  one-cycle pulse from the array: result11..result22 are valid this cycle
result11  input  DATA_W  array output row 1 col 1
result12  input  DATA_W  array output row 1 col 2
result21  input  DATA_W  array output row 2 col 1
result22  input  DATA_W  array output row 2 col 2
out_data  output  DATA_W  current element
out_idx  output  2  element index: 0=r11, 1=r12, 2=r21, 3=r22
out_tile  output  TILE_W  tile number of the current element
out_valid  output  1  out_data/out_idx/out_tile/out_last valid
out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high
out_last  output  1  high with out_idx==3
busy  output  1  high while a tile is held (state SEND)
tile_done  output  1  one-cycle pulse, the cycle after the idx-3 handshake
overrun  output  1  sticky, set when done_in is dropped
clr_overrun  input  1  clears overrun

Behaviour:
- Reset values: all outputs 0, holding bank 0, tile counter 0, idx 0, state IDLE. rst overrides everything. Reset mid-tile discards the held tile; no tile_done is issued for it.
- States:
  - IDLE: out_valid=0. done_in captures the four results (ReLU-processed if RELU_EN) into the bank, sets idx=0, and moves to SEND. out_valid rises the cycle after done_in (latency 1).
  - SEND: out_valid=1, out_data=bank[idx], out_last=(idx==3).
    - No handshake: all outputs hold stable.
    - Handshake with idx<3: idx increments.
    - Handshake with idx==3: tile_done pulses next cycle, tile counter increments (modulo 2^TILE_W), and the FSM returns to IDLE.
- done_in in SEND:
  - Without an idx-3 handshake in the same cycle: the tile is dropped, overrun is set, and the bank is unchanged.
  - Coinciding with the idx-3 handshake: the new tile is captured, idx=0, state stays SEND (out_valid stays 1, no bubble), tile_done still pulses, and the tile counter increments. No overrun.
- overrun: clr_overrun clears it. If set and clear occur in the same cycle, set wins.
- ReLU: element = MSB ? 0 : value. With RELU_EN=0 values pass unmodified. No other arithmetic.
- out_tile is the counter value at the moment of capture, held in the bank alongside the data.
- busy == (state==SEND).

Test Plan:
- Basic drain, out_ready tied 1: rst, then done_in with results 8'h11,8'h22,8'h33,8'h44. Required:
  - out_valid high cycles 1-4 after done_in;
  - out_data 11,22,33,44 with out_idx 0-3;
  - out_last only on 44;
  - tile_done at cycle 5, out_tile=0, busy low at cycle 5.
- Backpressure: same stimulus, out_ready low for 3 cycles at idx 1. Required: out_data=8'h22 and out_idx=1 held stable all 3 cycles, then the sequence resumes; no lost or duplicated beats.
- Overrun: second done_in (results 8'hAA..) while idx=1 and out_ready=0. Required:
  - overrun=1 next cycle;
  - streamed data still 11,22,33,44;
  - clr_overrun asserted in the same cycle as another dropped done_in leaves overrun=1; a lone clr_overrun clears it.
- Back-to-back: done_in with 8'h55..8'h88 coincident with the idx-3 handshake. Required:
  - out_valid stays high;
  - next beats 55,66,77,88 with out_tile=1;
  - tile_done pulses once per tile; overrun=0.
- ReLU with RELU_EN=1: results 8'h80,8'h7F,8'hFF,8'h00. Required: out_data 00,7F,00,00. With RELU_EN=0: values unchanged.
- Reset mid-drain plus wrap: rst at idx 2 gives all outputs 0 next cycle and no tile_done. With TILE_W=2, five tiles give out_tile 0,1,2,3,0.
